// File: rtl/cpu_types_pkg.sv
// Shared types for the MSI data cache: coherence states, FSM states, geometry and set entry layout.
package cpu_types_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned TAG_W     = 26;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned SETS      = 8;
  localparam int unsigned BLK_WORDS = 2;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [2:0] {
    IDLE,
    UPG,
    WB0,
    WB1,
    LD0,
    LD1,
    SNPWB0,
    SNPWB1
  } dc_state_t;

  typedef struct packed {
    msi_t                               st;
    logic [TAG_W-1:0]                   tag;
    logic [BLK_WORDS-1:0][WORD_W-1:0]   data;
  } dcache_entry_t;

endpackage

// File: rtl/dcache_tag_lookup.sv
// Combinational hit/state/word decode of one already-indexed cache set.
module dcache_tag_lookup
  import cpu_types_pkg::*;
(
  input  dcache_entry_t       entry_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic                off_i,
  output logic                hit_o,
  output msi_t                msi_o,
  output logic [WORD_W-1:0]   word_o
);

  always_comb begin
    msi_o  = entry_i.st;
    hit_o  = (entry_i.st != MSI_I) && (entry_i.tag == tag_i);
    word_o = entry_i.data[off_i];
  end

endmodule

// File: rtl/dcache_msi.sv
// Direct-mapped 8-set, 2-word-block write-back data cache with MSI snooping coherence.
module dcache_msi
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [31:0]       dmemaddr,
  input  logic [31:0]       dmemstore,
  output logic              dhit,
  output logic [31:0]       dmemload,
  output logic              dREN,
  output logic              dWEN,
  output logic [31:0]       daddr,
  output logic [31:0]       dstore,
  input  logic              dwait,
  input  logic [31:0]       dload,
  output logic              cctrans,
  output logic              ccwrite,
  input  logic              ccwait,
  input  logic              ccinv,
  input  logic [31:0]       ccsnoopaddr
);

  dcache_entry_t     cache_q [SETS];
  dc_state_t         state_q, state_d;
  logic [IDX_W-1:0]  snp_idx_q, snp_idx_d;
  logic              snp_inv_q, snp_inv_d;

  logic [TAG_W-1:0]  c_tag, s_tag;
  logic [IDX_W-1:0]  c_idx, s_idx;
  logic              c_off;
  dcache_entry_t     c_entry, s_entry;
  logic              c_hit, s_hit;
  msi_t              c_msi, s_msi;
  logic [WORD_W-1:0] c_word, snp_word;
  logic [WORD_W-1:0] victim_addr, blk_addr;

  logic wr_hit, set_m, fill0, fill1, drop_victim, snp_inval, snp_done;

  assign c_tag   = dmemaddr[31:6];
  assign c_idx   = dmemaddr[5:3];
  assign c_off   = dmemaddr[2];
  assign s_tag   = ccsnoopaddr[31:6];
  assign s_idx   = ccsnoopaddr[5:3];
  assign c_entry = cache_q[c_idx];
  assign s_entry = cache_q[s_idx];

  assign victim_addr = {c_entry.tag, c_idx, 3'b000};
  assign blk_addr    = {dmemaddr[31:3], 3'b000};

  logic unused_ok;
  assign unused_ok = ^{dmemaddr[1:0], ccsnoopaddr[1:0], snp_word};

  dcache_tag_lookup u_core_lookup (
    .entry_i (c_entry),
    .tag_i   (c_tag),
    .off_i   (c_off),
    .hit_o   (c_hit),
    .msi_o   (c_msi),
    .word_o  (c_word)
  );

  dcache_tag_lookup u_snoop_lookup (
    .entry_i (s_entry),
    .tag_i   (s_tag),
    .off_i   (ccsnoopaddr[2]),
    .hit_o   (s_hit),
    .msi_o   (s_msi),
    .word_o  (snp_word)
  );

  // Next state, bus/core outputs and array update strobes.
  always_comb begin
    state_d     = state_q;
    snp_idx_d   = snp_idx_q;
    snp_inv_d   = snp_inv_q;
    dhit        = 1'b0;
    dmemload    = '0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    cctrans     = 1'b0;
    ccwrite     = 1'b0;
    wr_hit      = 1'b0;
    set_m       = 1'b0;
    fill0       = 1'b0;
    fill1       = 1'b0;
    drop_victim = 1'b0;
    snp_inval   = 1'b0;
    snp_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ccwait) begin
          if (s_hit && (s_msi == MSI_M)) begin
            cctrans   = 1'b1;
            state_d   = SNPWB0;
            snp_idx_d = s_idx;
            snp_inv_d = ccinv;
          end else if (s_hit && (s_msi == MSI_S) && ccinv) begin
            snp_inval = 1'b1;
          end
        end else if (dmemREN || dmemWEN) begin
          if (c_hit && (dmemREN || (c_msi == MSI_M))) begin
            dhit     = 1'b1;
            dmemload = dmemREN ? c_word : '0;
            wr_hit   = dmemWEN;
          end else if (c_hit) begin
            state_d = UPG;
          end else if (c_msi == MSI_M) begin
            state_d = WB0;
          end else begin
            state_d     = LD0;
            drop_victim = 1'b1;
          end
        end
      end
      UPG: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        if (!dwait) begin
          set_m   = 1'b1;
          state_d = IDLE;
        end
      end
      WB0: begin
        dWEN    = 1'b1;
        cctrans = 1'b1;
        daddr   = victim_addr;
        dstore  = c_entry.data[0];
        if (!dwait) state_d = WB1;
      end
      WB1: begin
        dWEN    = 1'b1;
        cctrans = 1'b1;
        daddr   = victim_addr | 32'h4;
        dstore  = c_entry.data[1];
        // Victim is fully written back; invalidate before the refill overwrites it.
        if (!dwait) begin
          state_d     = LD0;
          drop_victim = 1'b1;
        end
      end
      LD0: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = blk_addr;
        if (!dwait) begin
          fill0   = 1'b1;
          state_d = LD1;
        end
      end
      LD1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = blk_addr | 32'h4;
        if (!dwait) begin
          fill1   = 1'b1;
          state_d = IDLE;
        end
      end
      SNPWB0: begin
        dstore = cache_q[snp_idx_q].data[0];
        if (!dwait) state_d = SNPWB1;
      end
      SNPWB1: begin
        dstore = cache_q[snp_idx_q].data[1];
        if (!dwait) begin
          snp_done = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase

    // Keep every output quiet while reset is held, whatever the array holds.
    if (!nRST) begin
      dhit     = 1'b0;
      dmemload = '0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      cctrans  = 1'b0;
      ccwrite  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      snp_idx_q <= '0;
      snp_inv_q <= 1'b0;
      for (int unsigned i = 0; i < SETS; i++) cache_q[IDX_W'(i)] <= '0;
    end else begin
      state_q   <= state_d;
      snp_idx_q <= snp_idx_d;
      snp_inv_q <= snp_inv_d;
      if (wr_hit)      cache_q[c_idx].data[c_off] <= dmemstore;
      if (set_m)       cache_q[c_idx].st          <= MSI_M;
      if (drop_victim) cache_q[c_idx].st          <= MSI_I;
      if (fill0)       cache_q[c_idx].data[0]     <= dload;
      if (fill1) begin
        cache_q[c_idx].data[1] <= dload;
        cache_q[c_idx].tag     <= c_tag;
        cache_q[c_idx].st      <= dmemWEN ? MSI_M : MSI_S;
      end
      if (snp_inval)   cache_q[s_idx].st          <= MSI_I;
      if (snp_done)    cache_q[snp_idx_q].st      <= snp_inv_q ? MSI_I : MSI_S;
    end
  end

endmodule
